// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: widths, funct3 codes, FSM states and load/alignment helpers
package dmem_access_unit_pkg;
  localparam int XLEN = 32;
  localparam int ALEN = 32;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} dmem_state_e;
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    return (funct3 == F3_LW && off != 2'b00) || ((funct3 == F3_LH || funct3 == F3_LHU) && off[0]);
  endfunction
  // Reserved funct3 codes fall through to the full word
  function automatic logic [XLEN-1:0] extract_load(input logic [2:0] funct3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    return funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
           funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
           funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
           funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : word;
  endfunction
endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: word-wide req/gnt + rvalid/rdata data bus
interface dmem_access_unit_if;
  import dmem_access_unit_pkg::*;
  logic            req;
  logic            we;
  logic [ALEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  logic            err;
  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_access_unit_load_aligner.sv
// dmem_access_unit_load_aligner: selects and extends the addressed bytes of a loaded word
module dmem_access_unit_load_aligner
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);
  assign data_o = extract_load(funct3_i, off_i, word_i);
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: runs MEM-stage loads/stores on a variable-latency bus and stalls until done
module dmem_access_unit
  import dmem_access_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mem_re_i,
  input  logic             mem_we_i,
  input  logic [ALEN-1:0]  mem_addr_i,
  input  logic [XLEN-1:0]  mem_wdata_i,
  input  logic [3:0]       mem_be_i,
  input  logic [2:0]       mem_funct3_i,
  output logic             stall_o,
  output logic [XLEN-1:0]  load_data_o,
  output logic             load_valid_o,
  output logic             misaligned_o,
  output logic             bus_fault_o,
  dmem_access_unit_if.master bus
);
  dmem_state_e     state_q;
  logic [1:0]      off_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rdata_ext;
  logic            access;
  logic            mis;
  assign access       = rst_ni & (mem_re_i | mem_we_i);
  assign mis          = is_misaligned(mem_funct3_i, mem_addr_i[1:0]);
  assign stall_o      = ((state_q == IDLE) & access & ~mis) | (state_q == REQ) | (state_q == RSP);
  assign misaligned_o = (state_q == IDLE) & access & mis;
  dmem_access_unit_load_aligner u_aligner (
    .funct3_i (funct3_q),
    .off_i    (off_q),
    .word_i   (bus.rdata),
    .data_o   (rdata_ext)
  );
  // DONE always returns to IDLE without sampling inputs: the pipeline advances on that edge
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q      <= IDLE;
      off_q        <= '0;
      funct3_q     <= '0;
      bus.req      <= 1'b0;
      bus.we       <= 1'b0;
      bus.addr     <= '0;
      bus.wdata    <= '0;
      bus.be       <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      bus_fault_o  <= 1'b0;
    end else
      case (state_q)
        IDLE: if (access && !mis) begin
          state_q   <= REQ;
          off_q     <= mem_addr_i[1:0];
          funct3_q  <= mem_funct3_i;
          bus.req   <= 1'b1;
          bus.we    <= mem_we_i;
          bus.addr  <= {mem_addr_i[ALEN-1:2], 2'b00};
          bus.wdata <= mem_wdata_i << {mem_addr_i[1:0], 3'b000};
          bus.be    <= mem_we_i ? mem_be_i : 4'hF;
        end
        REQ: if (bus.gnt) begin
          bus.req <= 1'b0;
          state_q <= bus.we ? DONE : RSP;
        end
        RSP: if (bus.rvalid) begin
          state_q      <= DONE;
          load_valid_o <= 1'b1;
          bus_fault_o  <= bus.err;
          load_data_o  <= bus.err ? '0 : rdata_ext;
        end
        default: begin
          state_q      <= IDLE;
          load_valid_o <= 1'b0;
          bus_fault_o  <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed loads/stores against a reactive bus model with a load-data scoreboard
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_be_i = '0;
  logic [2:0]  mem_funct3_i = '0;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        misaligned_o;
  logic        bus_fault_o;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] sb[$];

  dmem_access_unit_if bus ();

  dmem_access_unit dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mem_re_i     (mem_re_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_be_i     (mem_be_i),
    .mem_funct3_i (mem_funct3_i),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .misaligned_o (misaligned_o),
    .bus_fault_o  (bus_fault_o),
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one aligned access; the bus grants after g waiting cycles and responds after r more
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int g, input int r,
                        input logic [31:0] rdata, input logic err, input logic [31:0] exp_data);
    int n, stalls, gw, rw;
    logic granted, seen;
    logic [31:0] exp_wd;
    exp_wd = wdata << (8 * addr[1:0]);
    if (!we) sb.push_back(exp_data);
    mem_re_i = !we; mem_we_i = we; mem_funct3_i = f3;
    mem_addr_i = addr; mem_wdata_i = wdata; mem_be_i = be;
    #1;
    n = 0; stalls = 0; gw = 0; rw = 0; granted = 1'b0; seen = 1'b0;
    while (stall_o && n < 50) begin
      n++; stalls++;
      if (bus.req && !seen) begin
        seen = 1'b1;
        chk("bus_addr", bus.addr, addr & ~32'h3);
        chk("bus_be", 32'(bus.be), 32'(we ? be : 4'hF));
        chk("bus_we", 32'(bus.we), 32'(we));
        if (we) chk("bus_wdata", bus.wdata, exp_wd);
      end
      bus.gnt    = bus.req && gw == g;
      bus.rvalid = granted && !we && rw == r;
      bus.rdata  = bus.rvalid ? rdata : 32'h0;
      bus.err    = bus.rvalid && err;
      if (bus.req && gw < g) gw++;
      if (granted && rw < r) rw++;
      if (bus.gnt) granted = 1'b1;
      @(negedge clk_i); #1;
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.err = 1'b0; bus.rdata = '0;
    end
    chk("no_timeout", 32'(n < 50), 32'd1);
    chk("req_seen", 32'(seen), 32'd1);
    chk("stall_cycles", stalls, we ? 2 + g : 3 + g + r);
    chk("done_valid", 32'(load_valid_o), 32'(!we));
    chk("done_fault", 32'(bus_fault_o), 32'(err && !we));
    chk("done_req", 32'(bus.req), 32'd0);
    if (load_valid_o && sb.size() > 0) chk("load_data", load_data_o, sb.pop_front());
    mem_re_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk_i); #1;
    chk("idle_stall", 32'(stall_o), 32'd0);
    chk("idle_valid", 32'(load_valid_o), 32'd0);
    chk("idle_fault", 32'(bus_fault_o), 32'd0);
    chk("idle_req", 32'(bus.req), 32'd0);
  endtask

  task automatic misalign(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    mem_re_i = !we; mem_we_i = we; mem_funct3_i = f3; mem_addr_i = addr;
    mem_wdata_i = 32'h1234_5678; mem_be_i = 4'b0011;
    #1;
    chk("mis_pulse", 32'(misaligned_o), 32'd1);
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_req", 32'(bus.req), 32'd0);
    @(negedge clk_i);
    mem_re_i = 1'b0; mem_we_i = 1'b0;
    #1;
    chk("mis_clear", 32'(misaligned_o), 32'd0);
    chk("mis_req_after", 32'(bus.req), 32'd0);
    chk("mis_stall_after", 32'(stall_o), 32'd0);
  endtask

  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
    mem_re_i = 1'b1; mem_funct3_i = F3_LW; mem_addr_i = 32'h100;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_valid", 32'(load_valid_o), 32'd0);
    chk("rst_mis", 32'(misaligned_o), 32'd0);
    chk("rst_fault", 32'(bus_fault_o), 32'd0);
    chk("rst_data", load_data_o, 32'h0);
    chk("rst_addr", bus.addr, 32'h0);
    mem_re_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    access(1'b0, F3_LW,  32'h100, 32'h0,        4'h0,    0, 2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    access(1'b1, F3_SB,  32'h203, 32'h0000_00A5, 4'b1000, 0, 0, 32'h0,        1'b0, 32'h0);
    access(1'b0, F3_LB,  32'h301, 32'h0,        4'h0,    0, 0, 32'h0000_8000, 1'b0, 32'hFFFF_FF80);
    access(1'b0, F3_LBU, 32'h301, 32'h0,        4'h0,    1, 1, 32'h0000_8000, 1'b0, 32'h0000_0080);
    access(1'b0, F3_LH,  32'h302, 32'h0,        4'h0,    0, 0, 32'h8001_0000, 1'b0, 32'hFFFF_8001);
    access(1'b0, F3_LHU, 32'h302, 32'h0,        4'h0,    2, 0, 32'h8001_0000, 1'b0, 32'h0000_8001);
    access(1'b0, F3_LW,  32'h404, 32'h0,        4'h0,    3, 0, 32'h0123_4567, 1'b0, 32'h0123_4567);
    access(1'b1, F3_SW,  32'h40C, 32'hCAFE_F00D, 4'hF,    2, 0, 32'h0,        1'b0, 32'h0);
    access(1'b1, F3_SH,  32'h502, 32'h0000_BEEF, 4'b1100, 1, 0, 32'h0,        1'b0, 32'h0);
    misalign(1'b0, F3_LW, 32'h102);
    misalign(1'b1, F3_SH, 32'h101);
    access(1'b0, F3_LW,  32'h600, 32'h0,        4'h0,    0, 1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    access(1'b0, F3_LW,  32'h604, 32'h0,        4'h0,    0, 0, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA);
    // reset while waiting in RSP, then a stray rvalid after release
    mem_re_i = 1'b1; mem_we_i = 1'b0; mem_funct3_i = F3_LW; mem_addr_i = 32'h700;
    @(negedge clk_i); #1;
    chk("rr_req", 32'(bus.req), 32'd1);
    bus.gnt = 1'b1;
    @(negedge clk_i); #1;
    bus.gnt = 1'b0;
    chk("rr_rsp_stall", 32'(stall_o), 32'd1);
    rst_ni = 1'b0; mem_re_i = 1'b0;
    #1;
    chk("rr_stall", 32'(stall_o), 32'd0);
    chk("rr_valid", 32'(load_valid_o), 32'd0);
    chk("rr_data", load_data_o, 32'h0);
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
    @(negedge clk_i); #1;
    bus.rvalid = 1'b0; bus.rdata = '0;
    chk("stray_valid", 32'(load_valid_o), 32'd0);
    chk("stray_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); #1;
    chk("stray_valid2", 32'(load_valid_o), 32'd0);
    chk("stray_data", load_data_o, 32'h0);
    // reset while the request is still waiting for grant
    mem_re_i = 1'b1; mem_addr_i = 32'h800;
    @(negedge clk_i); #1;
    chk("rq_req", 32'(bus.req), 32'd1);
    rst_ni = 1'b0; mem_re_i = 1'b0;
    #1;
    chk("rq_req_drop", 32'(bus.req), 32'd0);
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    access(1'b0, F3_LB,  32'h903, 32'h0,        4'h0,    0, 0, 32'h7F00_0000, 1'b0, 32'h0000_007F);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
